// File: rtl/dht11_bcd_reader.sv
// DHT11 single-wire reader: periodic trigger, 40-bit capture, checksum, BCD digits.
// Ports: clk, rstn (active-high async reset), in_out (open-drain data line),
//        information {hum_int,hum_dec,temp_int,temp_dec}, six BCD digits,
//        data_valid / read_err one-cycle pulses, clk_100khz display scan clock.
module dht11_bcd_reader #(
    parameter int CLK_FREQ_HZ    = 12000000,
    parameter int READ_PERIOD_US = 2000000,
    parameter int START_LOW_US   = 20000,
    parameter int BIT_THRESH_US  = 40,
    parameter int TIMEOUT_US     = 200
) (
    input  logic        clk,
    input  logic        rstn,
    inout  wire         in_out,
    output logic [31:0] information,
    output logic [3:0]  humidity_ten,
    output logic [3:0]  humidity_one,
    output logic [3:0]  humidity_decimal,
    output logic [3:0]  temp_ten,
    output logic [3:0]  temp_one,
    output logic [3:0]  temp_decimal,
    output logic        data_valid,
    output logic        read_err,
    output logic        clk_100khz
);

    localparam int CYC_PER_US = CLK_FREQ_HZ / 1000000;
    localparam int DIV_HALF   = CLK_FREQ_HZ / 200000;
    localparam int TW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_WAIT_ACK = 4'd2;
    localparam logic [3:0] S_ACK_LOW  = 4'd3;
    localparam logic [3:0] S_ACK_HIGH = 4'd4;
    localparam logic [3:0] S_BIT_LOW  = 4'd5;
    localparam logic [3:0] S_BIT_HIGH = 4'd6;
    localparam logic [3:0] S_CHECK    = 4'd7;

    logic [3:0]    state_q,    state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [31:0]   us_cnt_q,   us_cnt_d;
    logic [DW-1:0] div_cnt_q,  div_cnt_d;
    logic          clk100_q,   clk100_d;
    logic          sync1_q,    sync2_q,    prev_q;
    logic [5:0]    bit_cnt_q,  bit_cnt_d;
    logic [39:0]   shift_q,    shift_d;
    logic [31:0]   info_q,     info_d;
    logic [11:0]   hum_bcd_q,  hum_bcd_d;
    logic [11:0]   temp_bcd_q, temp_bcd_d;
    logic          valid_q,    valid_d;
    logic          err_q,      err_d;

    logic          tick;
    logic          timeout;
    logic          fall;
    logic          rise;
    logic [7:0]    sum;

    // Integer part to two BCD digits, saturating at 99.
    function automatic logic [7:0] int_bcd(input logic [7:0] v);
        logic [7:0] r;
        if (v >= 8'd100) begin
            r = 8'h99;
        end else begin
            r = {4'(v / 8'd10), 4'(v % 8'd10)};
        end
        return r;
    endfunction

    function automatic logic [3:0] dec_bcd(input logic [7:0] v);
        return 4'(v % 8'd10);
    endfunction

    // Open-drain: only ever pull low, and only during the start pulse.
    assign in_out = (state_q == S_START) ? 1'b0 : 1'bz;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        us_cnt_d   = us_cnt_q;
        div_cnt_d  = div_cnt_q + DW'(1);
        clk100_d   = clk100_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        info_d     = info_q;
        hum_bcd_d  = hum_bcd_q;
        temp_bcd_d = temp_bcd_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        fall = prev_q & ~sync2_q;
        rise = ~prev_q & sync2_q;
        tick = (tick_cnt_q == TW'(CYC_PER_US - 1));
        timeout = tick && (us_cnt_q == 32'(TIMEOUT_US - 1));
        sum = shift_q[39:32] + shift_q[31:24]
            + shift_q[23:16] + shift_q[15:8];

        if (div_cnt_q == DW'(DIV_HALF - 1)) begin
            div_cnt_d = '0;
            clk100_d  = ~clk100_q;
        end

        if (tick) begin
            tick_cnt_d = '0;
            us_cnt_d   = us_cnt_q + 32'd1;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tick && us_cnt_q == 32'(READ_PERIOD_US - 1)) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            S_START: begin
                if (tick && us_cnt_q == 32'(START_LOW_US - 1)) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (fall) begin
                    state_d = S_ACK_LOW;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_ACK_LOW: begin
                if (rise) begin
                    state_d = S_ACK_HIGH;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_ACK_HIGH: begin
                if (fall) begin
                    state_d = S_BIT_LOW;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_BIT_LOW: begin
                if (rise) begin
                    state_d = S_BIT_HIGH;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_BIT_HIGH: begin
                if (fall) begin
                    // Time since the rising edge decides the bit value.
                    shift_d = {shift_q[38:0],
                               us_cnt_q > 32'(BIT_THRESH_US)};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd39) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_BIT_LOW;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (sum == shift_q[7:0]) begin
                    info_d     = shift_q[39:8];
                    hum_bcd_d  = {int_bcd(shift_q[39:32]),
                                  dec_bcd(shift_q[31:24])};
                    temp_bcd_d = {int_bcd(shift_q[23:16]),
                                  dec_bcd(shift_q[15:8])};
                    valid_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Each state measures its own time from a clean microsecond origin.
        if (state_d != state_q) begin
            tick_cnt_d = '0;
            us_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            us_cnt_q   <= '0;
            div_cnt_q  <= '0;
            clk100_q   <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            info_q     <= '0;
            hum_bcd_q  <= '0;
            temp_bcd_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            us_cnt_q   <= us_cnt_d;
            div_cnt_q  <= div_cnt_d;
            clk100_q   <= clk100_d;
            sync1_q    <= in_out;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            info_q     <= info_d;
            hum_bcd_q  <= hum_bcd_d;
            temp_bcd_q <= temp_bcd_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign information      = info_q;
    assign humidity_ten     = hum_bcd_q[11:8];
    assign humidity_one     = hum_bcd_q[7:4];
    assign humidity_decimal = hum_bcd_q[3:0];
    assign temp_ten         = temp_bcd_q[11:8];
    assign temp_one         = temp_bcd_q[7:4];
    assign temp_decimal     = temp_bcd_q[3:0];
    assign data_valid       = valid_q;
    assign read_err         = err_q;
    assign clk_100khz       = clk100_q;

endmodule

// File: tb/tb_dht11_bcd_reader.sv
// Bench for dht11_bcd_reader: sensor model on a pulled-up line, frame-level
// reference model, default-clock instance for the scan-clock checks.
module tb_dht11_bcd_reader;

    localparam int US = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_def;
    logic sens_low;
    wire  line;
    wire  line_def;

    pullup (line);
    pullup (line_def);
    assign line = sens_low ? 1'b0 : 1'bz;

    logic [31:0] info, info_def;
    logic [3:0]  h_t, h_o, h_d, t_t, t_o, t_d;
    logic [3:0]  dh_t, dh_o, dh_d, dt_t, dt_o, dt_d;
    logic        dv, err, c100;
    logic        dv_def, err_def, c100_def;

    dht11_bcd_reader #(
        .CLK_FREQ_HZ(1000000), .READ_PERIOD_US(100), .START_LOW_US(50),
        .BIT_THRESH_US(40), .TIMEOUT_US(200)
    ) u_dut (
        .clk(clk), .rstn(rst), .in_out(line), .information(info),
        .humidity_ten(h_t), .humidity_one(h_o), .humidity_decimal(h_d),
        .temp_ten(t_t), .temp_one(t_o), .temp_decimal(t_d),
        .data_valid(dv), .read_err(err), .clk_100khz(c100)
    );

    dht11_bcd_reader u_def (
        .clk(clk), .rstn(rst_def), .in_out(line_def), .information(info_def),
        .humidity_ten(dh_t), .humidity_one(dh_o), .humidity_decimal(dh_d),
        .temp_ten(dt_t), .temp_one(dt_o), .temp_decimal(dt_d),
        .data_valid(dv_def), .read_err(err_def), .clk_100khz(c100_def)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    logic [31:0] m_info;

    always @(negedge clk) begin
        cyc++;
        if (dv === 1'b1) dv_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference digits: integer part saturates at 99, decimal keeps its ones digit.
    function automatic logic [11:0] digs(input logic [7:0] i, input logic [7:0] d);
        int iv, dvv;
        iv  = int'(i);
        dvv = int'(d);
        if (iv >= 100) return {4'd9, 4'd9, 4'(dvv % 10)};
        return {4'(iv / 10), 4'(iv % 10), 4'(dvv % 10)};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".info"}, info, m_info);
        chk({tag, ".hum"}, {20'd0, h_t, h_o, h_d},
            {20'd0, digs(m_info[31:24], m_info[23:16])});
        chk({tag, ".temp"}, {20'd0, t_t, t_o, t_d},
            {20'd0, digs(m_info[15:8], m_info[7:0])});
    endtask

    task automatic hold(input logic lv, input int us);
        sens_low = lv;
        repeat (us * US) @(negedge clk);
    endtask

    task automatic wait_start(output int low, output int t_low);
        int n;
        n = 0;
        while (line !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", {31'd0, line}, 32'd0);
        t_low = cyc;
        low = 0;
        while (line === 1'b0 && low < 400) begin
            @(negedge clk);
            low++;
        end
    endtask

    task automatic respond(input logic [39:0] fr, input int nbits,
                           input int hi0, input int hi1);
        hold(1'b0, $urandom_range(40, 20));
        hold(1'b1, 80);
        hold(1'b0, 80);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b1, $urandom_range(50, 30));
            hold(1'b0, fr[39 - i] ? hi1 : hi0);
        end
        if (nbits == 40) begin
            hold(1'b1, 50);
            sens_low = 1'b0;
        end
    endtask

    task automatic do_frame(input string tag, input logic [39:0] fr,
                            input bit skip_start, input int hi0, input int hi1,
                            output int low, output int t_low);
        int dv0, e0, sum;
        bit good;
        dv0 = dv_cnt;
        e0  = err_cnt;
        low = 0;
        t_low = 0;
        if (!skip_start) wait_start(low, t_low);
        respond(fr, 40, hi0, hi1);
        hold(1'b0, 10);
        sum = int'(fr[39:32]) + int'(fr[31:24]) + int'(fr[23:16]) + int'(fr[15:8]);
        good = ((sum % 256) == int'(fr[7:0]));
        if (good) m_info = fr[39:8];
        chk({tag, ".dv"}, 32'(dv_cnt - dv0), good ? 32'd1 : 32'd0);
        chk({tag, ".err"}, 32'(err_cnt - e0), good ? 32'd0 : 32'd1);
        check_all(tag);
    endtask

    initial begin
        int lo, tl, t0, n, hi, dv0, e0;
        logic [7:0] b0, b1, b2, b3, ck;

        rst = 1'b1;
        rst_def = 1'b1;
        sens_low = 1'b0;
        m_info = '0;
        repeat (5) @(negedge clk);

        // Reset state of both instances.
        check_all("reset");
        chk("reset.dv_err", {30'd0, dv, err}, 32'd0);
        chk("reset.line", {31'd0, line}, 32'd1);
        chk("reset.c100", {31'd0, c100}, 32'd0);
        chk("def.outs", {info_def[31:2], c100_def, dv_def | err_def}, 32'd0);
        chk("def.digits", {8'd0, dh_t, dh_o, dh_d, dt_t, dt_o, dt_d}, 32'd0);
        chk("def.line", {31'd0, line_def}, 32'd1);

        // Scan clock of the default-parameter instance.
        rst_def = 1'b0;
        n = 0;
        while (c100_def !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_rng("c100.first_rise", n, 59, 61);
        hi = 0;
        while (c100_def === 1'b1 && hi < 200) begin
            @(negedge clk);
            hi++;
        end
        n = 0;
        while (c100_def === 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("c100.high", 32'(hi), 32'd60);
        chk("c100.low", 32'(n), 32'd60);

        // Good frame, first read one period after reset, 50 us host pulse.
        rst = 1'b0;
        t0 = cyc;
        do_frame("good", 40'h37_00_18_00_4F, 1'b0, 27, 70, lo, tl);
        chk("host_low", 32'(lo), 32'd50);
        chk_rng("first_read", tl - t0, 99, 101);
        chk("good.info_const", info, 32'h37001800);
        chk("good.digits", {8'd0, h_t, h_o, h_d, t_t, t_o, t_d}, 32'h00550240);

        // Bad checksum keeps the previous values.
        do_frame("badck", 40'h37_00_18_00_50, 1'b0, 27, 70, lo, tl);
        chk("badck.info_const", info, 32'h37001800);

        // Silent sensor: timeout in WAIT_ACK, retry one period later.
        e0 = err_cnt;
        dv0 = dv_cnt;
        wait_start(lo, tl);
        n = 0;
        while (err !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk_rng("timeout.lat", n, 198, 202);
        chk("timeout.line", {31'd0, line}, 32'd1);
        n = 0;
        while (line !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk_rng("timeout.retry", n, 98, 102);
        chk("timeout.err", 32'(err_cnt - e0), 32'd1);
        chk("timeout.dv", 32'(dv_cnt - dv0), 32'd0);
        check_all("timeout");
        n = 0;
        while (line === 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("retry.low", 32'(n), 32'd50);

        // 27 us / 70 us bits, answered on the retried start.
        do_frame("f2", 40'h63_05_09_03_74, 1'b1, 27, 70, lo, tl);
        chk("f2.digits", {8'd0, h_t, h_o, h_d, t_t, t_o, t_d}, 32'h00995093);

        // Randomized frames, including saturation and corrupted checksums.
        for (int r = 0; r < 4; r++) begin
            b0 = 8'($urandom_range(255, 0));
            b1 = 8'($urandom_range(99, 0));
            b2 = 8'($urandom_range(255, 0));
            b3 = 8'($urandom_range(99, 0));
            ck = b0 + b1 + b2 + b3;
            if (r == 2) ck = ck + 8'($urandom_range(255, 1));
            do_frame($sformatf("rnd%0d", r), {b0, b1, b2, b3, ck}, 1'b0,
                     $urandom_range(30, 20), $urandom_range(75, 60), lo, tl);
        end

        // Reset in the middle of a frame (after bit 20).
        wait_start(lo, tl);
        respond(40'h11_22_33_44_AA, 20, 27, 70);
        rst = 1'b1;
        #1;
        m_info = '0;
        chk("midrst.line", {31'd0, line}, 32'd1);
        check_all("midrst");
        chk("midrst.dv_err", {30'd0, dv, err}, 32'd0);
        repeat (3) @(negedge clk);
        e0 = err_cnt;
        dv0 = dv_cnt;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst.pulses", 32'((err_cnt - e0) + (dv_cnt - dv0)), 32'd0);
        check_all("midrst.after");

        // Reset while the host is pulling low releases the line at once.
        n = 0;
        while (line !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("startrst.low", {31'd0, line}, 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("startrst.line", {31'd0, line}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dht11_bcd_reader.md
Name: dht11_bcd_reader

Overview:
- Single-wire DHT11 humidity/temperature front end.
- Periodically triggers the sensor over an open-drain bidirectional pin and captures the 40-bit frame.
- Verifies the checksum, holds the upper 32 bits, and converts the integer and decimal bytes to BCD digits for the 4-digit seven-segment scanner.
- Also produces the 100 kHz scan clock used by the display multiplexer.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency; must be a multiple of 1 MHz.
- READ_PERIOD_US, 2000000, interval between sensor reads; the first read starts READ_PERIOD_US after reset.
- START_LOW_US, 20000, host start-pulse low time.
- BIT_THRESH_US, 40, high-pulse length above which a bit is 1.
- TIMEOUT_US, 200, maximum time allowed in any wait-for-edge phase.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rstn  input  1  asynchronous, active-high reset (the codebase port name is kept; polarity is fixed as active-high).
- in_out  inout  1  DHT11 data line; driven 0 or released to Z, never driven 1; external pull-up.
- information  output  32  {hum_int, hum_dec, temp_int, temp_dec} of the last valid frame.
- humidity_ten, humidity_one, humidity_decimal  output  4 each  BCD digits of humidity.
- temp_ten, temp_one, temp_decimal  output  4 each  BCD digits of temperature.
- data_valid  output  1  one-cycle pulse when information updates.
- read_err  output  1  one-cycle pulse on checksum failure or timeout.
- clk_100khz  output  1  50% square wave at CLK_FREQ_HZ/120 for the default clock, i.e. 100 kHz.

Behaviour:

Reset:
- All outputs are 0 and in_out is released (Z).
- The FSM is in IDLE and all counters are cleared.

Timebase and divider:
- A 1 µs tick is generated every CLK_FREQ_HZ/1e6 clk cycles.
- clk_100khz toggles every CLK_FREQ_HZ/200000 clk cycles (60 at default) and starts low after reset.

Input synchronisation:
- in_out is sampled through a 2-flop synchronizer; all edge detection uses the synchronized value.

FSM (µs counter resets on every state change):
- IDLE: wait READ_PERIOD_US, then go to START.
- START: drive 0 for START_LOW_US, then release and go to WAIT_ACK.
- WAIT_ACK: wait for line low, then ACK_LOW.
- ACK_LOW: wait for high, then ACK_HIGH.
- ACK_HIGH: wait for low, then BIT_LOW.
- BIT_LOW: wait for high, then BIT_HIGH.
- BIT_HIGH: on the falling edge, shift in bit = (high time > BIT_THRESH_US), MSB first. If fewer than 40 bits have been received, return to BIT_LOW; otherwise go to CHECK.
- CHECK: if (b39..32 + b31..24 + b23..16 + b15..8) mod 256 == b7..0, load information, update the BCD digits and pulse data_valid. Otherwise pulse read_err and keep the old values. Then return to IDLE.
- Timeout: any wait state exceeding TIMEOUT_US pulses read_err, releases the line and returns to IDLE; outputs are unchanged.

BCD conversion (registered, same cycle as the information update):
- humidity_ten = hum_int/10 and humidity_one = hum_int%10.
- hum_int values ≥100 saturate to 9/9.
- humidity_decimal = hum_dec%10.
- The temperature digits follow the same rules.

Driving rules and priority:
- in_out is driven only in START.
- The bit counter and shift register clear on entry to START.
- Reset asserted mid-frame immediately releases the line and returns to IDLE; a partial frame is discarded.
- Checksum arithmetic is 8-bit wrap-around.

Test Plan:
1. Reset, then hold the line high → in_out is Z, outputs are 0, clk_100khz period is 120 clk cycles with 60 high.
2. Scaled parameters (READ_PERIOD_US=100, START_LOW_US=50). Sensor model answers with 80/80 µs ack and frame 0x37,0x00,0x18,0x00,0x4F → information=0x37001800; digits hum 5,5,0 and temp 2,4,0; one data_valid pulse. Also check the host low pulse lasts exactly 50 µs.
3. Frame with checksum 0x50 following a good frame → read_err pulses and information stays 0x37001800.
4. No sensor response (line stays high after release) → read_err after 200 µs in WAIT_ACK, line released, next read retried one period later.
5. Bit high times of 27 µs and 70 µs → decoded as 0 and 1 respectively. Frame 0x63,0x05,0x09,0x03,0x74 → digits hum 9,9,5 and temp 0,9,3.
6. Assert rstn mid-frame (bit 20) → line released at once, all outputs return to 0.
